// File: rtl/spork_mem_pkg.sv
// Shared types for the data-memory arbiter.
// Widths match the DataMemory macro.
package spork_mem_pkg;

  localparam int SPORK_ADDR_W = 8;
  localparam int SPORK_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } mem_state_t;

  typedef enum logic {
    PORT_CORE,
    PORT_DMA
  } mem_port_t;

  typedef struct packed {
    logic                    we;
    logic [SPORK_ADDR_W-1:0] addr;
    logic [SPORK_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port DataMemory.
// Core has priority; a wait counter bounds DMA starvation.
module data_mem_arbiter
  import spork_mem_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  mem_state_t        state;
  mem_port_t         winner;
  logic [3:0]        wait_cnt;
  logic              dma_wins;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    dma_wins  = dma_req && (!core_req || wait_cnt == WAIT_MAX);
    sel_we    = dma_wins ? dma_we    : core_we;
    sel_addr  = dma_wins ? dma_addr  : core_addr;
    sel_wdata = dma_wins ? dma_wdata : core_wdata;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      winner     <= PORT_CORE;
      wait_cnt   <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_ack   <= 1'b0;
      dma_ack    <= 1'b0;
      core_rdata <= '0;
      dma_rdata  <= '0;
    end else begin
      core_ack <= 1'b0;
      dma_ack  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (core_req || dma_req) begin
            state     <= ACCESS;
            winner    <= dma_wins ? PORT_DMA : PORT_CORE;
            mem_read  <= !sel_we;
            mem_write <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            // only a contested loss counts toward the DMA's turn
            if (dma_wins)
              wait_cnt <= '0;
            else if (dma_req && wait_cnt < WAIT_MAX)
              wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ACCESS: begin
          state     <= DONE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          if (winner == PORT_DMA) begin
            dma_ack <= 1'b1;
            if (mem_read) dma_rdata <= mem_rdata;
          end else begin
            core_ack <= 1'b1;
            if (mem_read) core_rdata <= mem_rdata;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed and random checks of data_mem_arbiter against
// a transaction-level model of the shared memory.
module tb_data_mem_arbiter;

  localparam int MAX_WAIT = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       core_req = 1'b0, core_we = 1'b0;
  logic [7:0] core_addr = '0, core_wdata = '0;
  logic       core_ack;
  logic [7:0] core_rdata;
  logic       dma_req = 1'b0, dma_we = 1'b0;
  logic [7:0] dma_addr = '0, dma_wdata = '0;
  logic       dma_ack;
  logic [7:0] dma_rdata;
  logic       mem_read, mem_write;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       busy;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .ADDR_W(8), .DATA_W(8), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // DataMemory stand-in
  logic [7:0] mem [256];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem_read ? mem[mem_addr] : 8'h00;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [7:0] ref_mem [256];
  int         losses = 0;
  logic [7:0] exp_crd = '0;
  logic [7:0] exp_drd = '0;
  bit         w;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_core(input logic r, input logic we,
                          input logic [7:0] a, input logic [7:0] d);
    core_req = r; core_we = we; core_addr = a; core_wdata = d;
  endtask

  task automatic set_dma(input logic r, input logic we,
                         input logic [7:0] a, input logic [7:0] d);
    dma_req = r; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, " cmd"}, {mem_read, mem_write}, 0);
    chk({tag, " addr"}, mem_addr, 0);
    chk({tag, " wdata"}, mem_wdata, 0);
    chk({tag, " acks"}, {core_ack, dma_ack}, 0);
    chk({tag, " crd"}, core_rdata, 0);
    chk({tag, " drd"}, dma_rdata, 0);
    chk({tag, " busy"}, busy, 0);
  endtask

  // Called at a negedge in an idle cycle with requests already driven;
  // returns at the negedge of the next idle cycle.
  task automatic run_one(input string tag, output bit won_dma);
    bit         ed;
    bit         we;
    logic [7:0] a, wd;
    int         n;
    bit         got;
    chk({tag, " idle"}, busy, 0);
    if (core_req && dma_req) begin
      if (losses == MAX_WAIT) begin ed = 1; losses = 0; end
      else begin ed = 0; losses++; end
    end else if (dma_req) begin
      ed = 1; losses = 0;
    end else begin
      ed = 0;
    end
    we = ed ? dma_we : core_we;
    a  = ed ? dma_addr : core_addr;
    wd = ed ? dma_wdata : core_wdata;
    @(negedge clk);
    chk({tag, " c1 wr"}, mem_write, we);
    chk({tag, " c1 rd"}, mem_read, !we);
    chk({tag, " c1 addr"}, mem_addr, a);
    if (we) chk({tag, " c1 wdata"}, mem_wdata, wd);
    chk({tag, " c1 acks"}, {core_ack, dma_ack}, 0);
    n = 1;
    got = 0;
    while (!got && n < 6) begin
      @(negedge clk);
      n++;
      got = core_ack | dma_ack;
    end
    chk({tag, " latency"}, n, 2);
    chk({tag, " ack who"}, {core_ack, dma_ack}, ed ? 2'b01 : 2'b10);
    chk({tag, " c2 cmd"}, {mem_read, mem_write}, 0);
    chk({tag, " c2 addr"}, mem_addr, 0);
    if (we) ref_mem[a] = wd;
    else if (ed) exp_drd = ref_mem[a];
    else exp_crd = ref_mem[a];
    chk({tag, " crd"}, core_rdata, exp_crd);
    chk({tag, " drd"}, dma_rdata, exp_drd);
    @(negedge clk);
    chk({tag, " ack pulse"}, {core_ack, dma_ack}, 0);
    chk({tag, " c3 cmd"}, {mem_read, mem_write}, 0);
    won_dma = ed;
  endtask

  task automatic drain(input string tag);
    bit dw;
    for (int k = 0; k < 4 && (core_req || dma_req); k++) begin
      run_one(tag, dw);
      if (dw) set_dma(0, 0, 0, 0);
      else set_core(0, 0, 0, 0);
    end
  endtask

  initial begin
    @(negedge clk);
    all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    set_core(1, 1, 8'h00, 8'h0F);
    run_one("t1_wr", w);
    set_core(1, 0, 8'h00, 8'h00);
    run_one("t1_rd", w);
    chk("t1 rdata", core_rdata, 8'h0F);
    set_core(0, 0, 0, 0);

    set_core(1, 1, 8'h0C, 8'h04);
    run_one("t2_wr4", w);
    set_core(1, 1, 8'h0C, 8'h06);
    run_one("t2_wr6", w);
    set_core(0, 0, 0, 0);
    set_dma(1, 0, 8'h0C, 8'h00);
    run_one("t2_rd", w);
    chk("t2 dma rdata", dma_rdata, 8'h06);
    chk("t2 core rdata", core_rdata, 8'h0F);
    set_dma(0, 0, 0, 0);

    set_dma(1, 1, 8'h05, 8'hA5);
    run_one("t4_wr", w);
    chk("t4 wr winner", w, 1);
    set_dma(1, 0, 8'h05, 8'h00);
    run_one("t4_rd", w);
    chk("t4 rd winner", w, 1);
    chk("t4 rdata", dma_rdata, 8'hA5);
    chk("t4 wait_cnt", dut.wait_cnt, 0);
    set_dma(0, 0, 0, 0);

    set_core(1, 1, 8'h30, 8'($urandom));
    set_dma(1, 1, 8'h40, 8'($urandom));
    for (int i = 0; i < 8; i++) begin
      run_one("t3", w);
      chk($sformatf("t3 order %0d", i), w, (i % 4) == 3);
      if (w) set_dma(1, 1, 8'(8'h41 + i), 8'($urandom));
      else set_core(1, 1, 8'(8'h31 + i), 8'($urandom));
    end
    drain("t3_drain");

    set_core(1, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("t5 in access", mem_read, 1);
    #1 reset_n = 1'b0;
    #1 all_zero("t5 async");
    losses = 0;
    exp_crd = '0;
    exp_drd = '0;
    repeat (2) begin
      @(negedge clk);
      chk("t5 no ack", {core_ack, dma_ack}, 0);
    end
    reset_n = 1'b1;
    run_one("t5_reread", w);
    chk("t5 rdata", core_rdata, 8'h0F);
    set_core(0, 0, 0, 0);

    set_dma(1, 0, 8'h05, 8'h00);
    run_one("t6_prep", w);
    set_dma(0, 0, 0, 0);
    repeat (10) begin
      @(negedge clk);
      chk("t6 busy", busy, 0);
      chk("t6 cmd", {mem_read, mem_write}, 0);
      chk("t6 crd", core_rdata, 8'h0F);
      chk("t6 drd", dma_rdata, 8'hA5);
    end

    for (int i = 0; i < 8; i++) begin
      set_core(1, 1, 8'(8'h20 + i), 8'($urandom));
      run_one("rnd_init", w);
    end
    set_core(0, 0, 0, 0);
    for (int r = 0; r < 40; r++) begin
      if (!core_req && $urandom_range(0, 1) == 1)
        set_core(1, 1'($urandom_range(0, 1)),
                 8'(8'h20 + $urandom_range(0, 7)), 8'($urandom));
      if (!dma_req && $urandom_range(0, 1) == 1)
        set_dma(1, 1'($urandom_range(0, 1)),
                8'(8'h20 + $urandom_range(0, 7)), 8'($urandom));
      if (!core_req && !dma_req)
        set_core(1, 1'($urandom_range(0, 1)),
                 8'(8'h20 + $urandom_range(0, 7)), 8'($urandom));
      run_one("rnd", w);
      if (w) set_dma(0, 0, 0, 0);
      else set_core(0, 0, 0, 0);
    end
    drain("rnd_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port `DataMemory` (8-bit address, 8-bit data, synchronous write on `WriteMem`, combinational `DataOut` while `ReadMem`) between the processor load/store unit (core port) and the DMA/debug loader (dma port). It accepts one request per port with a req/ack handshake and issues exactly one memory access at a time. The core has fixed priority, and a starvation counter guarantees DMA progress. Its outputs connect directly to `DataMemory`'s `ReadMem`, `WriteMem`, `data_addr` and `DataIn`, and it takes in `DataOut`.

## Interface
- `ADDR_W`, default 8: address width.
- `DATA_W`, default 8: data width.
- `MAX_WAIT`, default 3: number of consecutive contested arbitrations the DMA may lose before it is forced to win (legal range 1–15).

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `core_req`, `core_we`  in  1  core request and write-enable.
- `core_addr`  in  ADDR_W  core address.
- `core_wdata`  in  DATA_W  core write data.
- `core_ack`  out  1  one-cycle completion pulse.
- `core_rdata`  out  DATA_W  core read data.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_ack`, `dma_rdata`  same as the core port.
- `mem_read`  out  1  drives `DataMemory.ReadMem`.
- `mem_write`  out  1  drives `DataMemory.WriteMem`.
- `mem_addr`  out  ADDR_W  drives `data_addr`.
- `mem_wdata`  out  DATA_W  drives `DataIn`.
- `mem_rdata`  in  DATA_W  from `DataOut`.
- `busy`  out  1  high when the FSM is not in IDLE.

## Operation
- The FSM has three states:
  - **IDLE**: samples requests.
  - **ACCESS**: drives the memory command.
  - **DONE**: pulses ack.
- IDLE → ACCESS happens when `core_req` or `dma_req` is high. Otherwise the FSM stays in IDLE.
- ACCESS → DONE and DONE → IDLE are unconditional.
- Arbitration, evaluated in IDLE:
  - Only one requester active: that requester wins.
  - Both requesting: the core wins unless `wait_cnt == MAX_WAIT`, in which case the DMA wins.
- `wait_cnt` rules:
  - Increments when both are requesting and the core wins.
  - Clears whenever the DMA wins.
  - Unchanged otherwise.
  - Saturates at `MAX_WAIT`.
- On the IDLE → ACCESS edge, the winner's we/addr/wdata are latched and the winner ID is stored.
- In ACCESS, the registered memory outputs are: `mem_read = !we`, `mem_write = we`, `mem_addr`, `mem_wdata`. Exactly one of `mem_read`/`mem_write` is high, and only in ACCESS.
- At the end of ACCESS, on a read, `mem_rdata` is captured into the winner's rdata register.
- In DONE, the winner's ack is high for exactly one cycle. `mem_read`, `mem_write`, `mem_addr` and `mem_wdata` return to 0.
- Each port's rdata register changes only on completion of a read for that port. It holds its value otherwise, including across writes.
- Requester rules:
  - Hold req/we/addr/wdata stable from assertion until ack is sampled high.
  - May drop req, or present a new request, in the cycle after ack.
  - Inputs that change while req is low or the requester is not the winner are ignored.
- A losing requester keeps req asserted and is served in a later arbitration. No request is ever dropped.

## Timing
- Latency: req high while in IDLE in cycle 0 → memory command in cycle 1 → ack and valid rdata in cycle 2.
- Throughput: one access per 3 cycles. Back-to-back requests re-arbitrate in cycle 3.
- Reset values: state IDLE, `wait_cnt` 0; every output 0 (`mem_read`, `mem_write`, `mem_addr`, `mem_wdata`, both acks, both rdata, `busy`).
- Reset mid-operation:
  - The FSM returns to IDLE immediately and no ack is issued.
  - A write already clocked into memory stays.
  - A read in flight is discarded.
- A simultaneous req rise on both ports in the same cycle is resolved by the arbitration rule above.

## Structure
- Shared package `spork_mem_pkg`:
  - `mem_state_t` enum {IDLE, ACCESS, DONE}
  - `mem_port_t` enum {PORT_CORE, PORT_DMA}
  - `mem_req_t` struct {we, addr, wdata}
  - Constants `SPORK_ADDR_W = 8` and `SPORK_DATA_W = 8`.
- Single module. No sub-module: the starvation counter and FSM are small enough to keep inline.
- Integration instantiates `data_mem_arbiter` next to `DataMemory`, sharing `clk`.

## Test plan
- Core write 0x0F to 0x00, then core read 0x00. Required: `mem_write` high for exactly one cycle, ack in cycle 2 of each access, `core_rdata` = 0x0F.
- Core writes 0x04 then 0x06 to 0x0C back-to-back, then DMA reads 0x0C. Required: `dma_rdata` = 0x06, and `core_rdata` is unchanged by the writes.
- Both ports request continuously with `MAX_WAIT=3`. Required grant order is core, core, core, dma, repeating, and every ack is a one-cycle pulse.
- DMA only, reading 0x05 after writing 0xA5. Required: served on first arbitration, `dma_rdata` = 0xA5, `wait_cnt` stays 0.
- Deassert `reset_n` during ACCESS of a core read. Required: all outputs 0 immediately and no `core_ack`. After release, a re-issued read completes normally.
- Idle with no req for 10 cycles. Required: `busy`, `mem_read` and `mem_write` remain 0, and both rdata values hold.
